i2c_txn_sequencer: RTL and testbench

- Byte/transaction-level controller directly upstream of the I2C bit engine, which holds the 9-bit tx_reg, clock_divisor_reg and the k_data* states.
- Turns one host request into the engine command sequence: START, address byte, N write or read bytes, STOP.
- Packs each byte with its ACK bit into the engine's 9-bit transmit word, MSB first, {byte, ack}.
- Collects read bytes and ACK/NACK status from the engine and returns them to the host.

---
 rtl/i2c_txn_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_i2c_txn_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_sequencer.sv
// Transaction sequencer in front of the I2C bit engine: expands one host request
// into START, address, data bytes and STOP commands, and reports read data and NACKs.
module i2c_txn_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_addr,
  input  logic             req_rw,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic             nack_err,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [1:0]       cmd_op,
  output logic [8:0]       cmd_tx,
  input  logic             cmd_done,
  input  logic [8:0]       cmd_rx
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_WWAIT = 3'd3;
  localparam logic [2:0] S_WDATA = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;
  localparam logic [2:0] S_STOP  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ZERO = '0;

  logic [2:0]       state_q,     state_d;
  logic [6:0]       addr_q,      addr_d;
  logic             rw_q,        rw_d;
  logic [LEN_W-1:0] remain_q,    remain_d;
  logic [7:0]       byte_q,      byte_d;
  logic             nack_q,      nack_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             wait_q,      wait_d;
  logic [1:0]       cmd_op_q,    cmd_op_d;
  logic [8:0]       cmd_tx_q,    cmd_tx_d;
  logic             rd_valid_q,  rd_valid_d;
  logic [7:0]       rd_data_q,   rd_data_d;

  logic             is_cmd_state;
  logic [1:0]       issue_op;
  logic [8:0]       issue_tx;
  logic             cmd_fin;
  logic             last_byte;
  logic [LEN_W-1:0] remain_dec;

  always_comb begin
    is_cmd_state = 1'b1;
    issue_op     = OP_START;
    issue_tx     = 9'h1FF;
    case (state_q)
      S_START: begin issue_op = OP_START; issue_tx = 9'h1FF; end
      S_ADDR:  begin issue_op = OP_WRITE; issue_tx = {addr_q, rw_q, 1'b1}; end
      S_WDATA: begin issue_op = OP_WRITE; issue_tx = {byte_q, 1'b1}; end
      // Master ACKs every read byte except the final one, which it NACKs.
      S_RDATA: begin issue_op = OP_READ;  issue_tx = {8'hFF, remain_q == LEN_ONE}; end
      S_STOP:  begin issue_op = OP_STOP;  issue_tx = 9'h1FF; end
      default: is_cmd_state = 1'b0;
    endcase
  end

  assign cmd_fin    = wait_q & cmd_done;
  assign last_byte  = (remain_q <= LEN_ONE);
  assign remain_dec = (remain_q != LEN_ZERO) ? remain_q - LEN_ONE : LEN_ZERO;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    remain_d    = remain_q;
    byte_d      = byte_q;
    nack_d      = nack_q;
    cmd_valid_d = cmd_valid_q;
    wait_d      = wait_q;
    cmd_op_d    = cmd_op_q;
    cmd_tx_d    = cmd_tx_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;

    // One command outstanding: raise, hold until accepted, then wait for its completion.
    if (is_cmd_state && !cmd_valid_q && !wait_q) begin
      cmd_valid_d = 1'b1;
      cmd_op_d    = issue_op;
      cmd_tx_d    = issue_tx;
    end
    if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
      wait_d      = 1'b1;
    end
    if (cmd_fin) begin
      wait_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          rw_d     = req_rw;
          remain_d = req_len;
          state_d  = S_START;
        end
      end
      S_START: if (cmd_fin) state_d = S_ADDR;
      S_ADDR: begin
        if (cmd_fin) begin
          if (cmd_rx[0]) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
          end else if (remain_q == LEN_ZERO) begin
            state_d = S_STOP;
          end else begin
            state_d = rw_q ? S_RDATA : S_WWAIT;
          end
        end
      end
      S_WWAIT: begin
        if (wr_valid) begin
          byte_d  = wr_data;
          state_d = S_WDATA;
        end
      end
      S_WDATA: begin
        if (cmd_fin) begin
          remain_d = remain_dec;
          if (cmd_rx[0]) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
          end else begin
            state_d = last_byte ? S_STOP : S_WWAIT;
          end
        end
      end
      S_RDATA: begin
        // cmd_rx[0] here is our own ACK echoed back, so it is not a target NACK.
        if (cmd_fin) begin
          rd_valid_d = 1'b1;
          rd_data_d  = cmd_rx[8:1];
          remain_d   = remain_dec;
          if (last_byte) state_d = S_STOP;
        end
      end
      S_STOP: if (cmd_fin) state_d = S_DONE;
      S_DONE: begin
        nack_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      remain_q    <= '0;
      byte_q      <= '0;
      nack_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      wait_q      <= 1'b0;
      cmd_op_q    <= '0;
      cmd_tx_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      remain_q    <= remain_d;
      byte_q      <= byte_d;
      nack_q      <= nack_d;
      cmd_valid_q <= cmd_valid_d;
      wait_q      <= wait_d;
      cmd_op_q    <= cmd_op_d;
      cmd_tx_q    <= cmd_tx_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign wr_ready  = (state_q == S_WWAIT) & wr_valid;
  assign done      = (state_q == S_DONE);
  assign nack_err  = (state_q == S_DONE) & nack_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_tx    = cmd_tx_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer: a table of transactions run against a
// simple bit-engine responder and host writer, plus reset/backpressure sequences.
module tb_i2c_txn_sequencer;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic [6:0]       req_addr;
  logic             req_rw;
  logic [LEN_W-1:0] req_len;
  logic             wr_valid;
  logic [7:0]       wr_data;
  logic             wr_ready;
  logic             rd_valid;
  logic [7:0]       rd_data;
  logic             done;
  logic             nack_err;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [8:0]       cmd_tx;
  logic             cmd_done;
  logic [8:0]       cmd_rx;

  i2c_txn_sequencer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rw(req_rw), .req_len(req_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .nack_err(nack_err),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_tx(cmd_tx),
    .cmd_done(cmd_done), .cmd_rx(cmd_rx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] len;
    logic [7:0] wdata [4];
    logic [7:0] rxdata [4];
    int         nack_cmd;
    int         addr_stall;
    int         wr_delay;
    int         n_cmd;
    int         exp_op [8];
    logic [8:0] exp_tx [8];
    int         n_rd;
    int         n_wr;
    logic       exp_nack;
  } vec_t;

  vec_t vecs [8];
  vec_t cur;
  int   checks = 0;
  int   failures = 0;
  logic tx_active = 1'b0;
  logic flush = 1'b0;
  logic clr = 1'b0;

  // Environment state, owned by the single responder process below.
  int         cmd_idx, busy, dly, rd_issue, stall_left, stall_obs, stall_bad;
  int         done_cnt, rd_cnt, wr_idx, acc_pend, gap, gap_cmds, wr_rdy_cnt;
  logic       addr_acked, done_nack;
  logic [8:0] rx_val, held_tx;
  int         log_op [16];
  logic [8:0] log_tx [16];
  logic [7:0] rd_log [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit-engine responder, host writer and output monitor, all sampled on negedge.
  initial begin
    cmd_ready = 1'b0; cmd_done = 1'b0; cmd_rx = '0;
    wr_valid = 1'b0; wr_data = '0;
    busy = 0; dly = 0;
    forever begin
      @(negedge clk);
      if (clr) begin
        cmd_idx = 0; rd_issue = 0; stall_left = cur.addr_stall; stall_obs = 0; stall_bad = 0;
        addr_acked = 1'b0; done_cnt = 0; rd_cnt = 0; done_nack = 1'b0; busy = 0;
        wr_idx = 0; acc_pend = 0; gap = cur.wr_delay; gap_cmds = 0; wr_rdy_cnt = 0;
      end
      if (done) begin done_cnt++; done_nack = nack_err; end
      if (rd_valid) begin
        if (rd_cnt < 8) rd_log[rd_cnt] = rd_data;
        rd_cnt++;
      end
      cmd_done = 1'b0;
      if (flush) begin
        busy = 0; cmd_ready = 1'b0;
      end else if (busy != 0) begin
        cmd_ready = 1'b0;
        if (dly == 0) begin
          cmd_done = 1'b1; cmd_rx = rx_val; busy = 0;
          if (cmd_idx == 2) addr_acked = 1'b1;
        end else dly--;
      end else if (cmd_valid) begin
        if (cmd_idx == 1 && stall_left > 0) begin
          cmd_ready = 1'b0;
          if (stall_obs == 0) held_tx = cmd_tx;
          else if (cmd_tx !== held_tx) stall_bad++;
          stall_obs++; stall_left--;
        end else begin
          if (cmd_idx == 1 && stall_obs > 0 && cmd_tx !== held_tx) stall_bad++;
          cmd_ready = 1'b1;
          if (cmd_idx < 16) begin log_op[cmd_idx] = int'(cmd_op); log_tx[cmd_idx] = cmd_tx; end
          case (cmd_op)
            2'd1: rx_val = {cmd_tx[8:1], (cmd_idx == cur.nack_cmd)};
            2'd2: begin rx_val = {cur.rxdata[rd_issue % 4], cmd_tx[0]}; rd_issue++; end
            default: rx_val = 9'h1FF;
          endcase
          cmd_idx++; busy = 1; dly = 2;
        end
      end else begin
        cmd_ready = 1'b0;
        if (cmd_idx == 1 && stall_obs > 0 && stall_left > 0) stall_bad++;
      end
      if (!tx_active) begin
        wr_valid = 1'b0;
      end else begin
        if (acc_pend != 0) begin wr_idx++; acc_pend = 0; end
        if (gap > 0) begin
          wr_valid = 1'b0;
          if (addr_acked) begin
            gap--;
            if (cmd_valid) gap_cmds++;
          end
        end else if (wr_idx < 4) begin
          wr_valid = 1'b1; wr_data = cur.wdata[wr_idx];
        end else wr_valid = 1'b0;
      end
      #1;
      if (wr_ready) wr_rdy_cnt++;
      if (wr_valid && wr_ready) acc_pend = 1;
    end
  end

  task automatic clear_env(input vec_t v);
    cur = v;
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic issue_req(input vec_t v, input string tag);
    @(negedge clk);
    req_valid = 1'b1; req_addr = v.addr; req_rw = v.rw; req_len = v.len;
    tx_active = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, " req_ready_after_accept"}, {31'd0, req_ready}, 32'd0);
  endtask

  task automatic run_vec(input int vi);
    vec_t  v;
    string tag;
    int    waited;
    v = vecs[vi];
    tag = $sformatf("v%0d", vi);
    clear_env(v);
    issue_req(v, tag);
    waited = 0;
    while (done_cnt == 0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (done_cnt == 0) chk({tag, " done_timeout"}, 32'd0, 32'd1);
    repeat (4) @(negedge clk);
    tx_active = 1'b0;
    chk({tag, " done_count"}, done_cnt, 32'd1);
    chk({tag, " nack_err"}, {31'd0, done_nack}, {31'd0, v.exp_nack});
    chk({tag, " cmd_count"}, cmd_idx, v.n_cmd);
    for (int i = 0; i < v.n_cmd && i < cmd_idx && i < 16; i++) begin
      chk($sformatf("%s cmd%0d op", tag, i), log_op[i], v.exp_op[i]);
      chk($sformatf("%s cmd%0d tx", tag, i), {23'd0, log_tx[i]}, {23'd0, v.exp_tx[i]});
    end
    chk({tag, " rd_count"}, rd_cnt, v.n_rd);
    for (int i = 0; i < v.n_rd && i < rd_cnt && i < 4; i++)
      chk($sformatf("%s rd%0d data", tag, i), {24'd0, rd_log[i]}, {24'd0, v.rxdata[i]});
    chk({tag, " wr_ready_cycles"}, wr_rdy_cnt, v.n_wr);
    chk({tag, " stall_cycles"}, stall_obs, v.addr_stall);
    chk({tag, " stall_unstable"}, stall_bad, 32'd0);
    chk({tag, " cmds_during_wwait"}, gap_cmds, 32'd0);
    chk({tag, " req_ready_idle"}, {31'd0, req_ready}, 32'd1);
    $display("txn %s rw=%0d addr=%02h len=%0d cmds=%0d rd=%0d done=%0d nack=%0d",
             tag, v.rw, v.addr, v.len, cmd_idx, rd_cnt, done_cnt, done_nack);
  endtask

  initial begin
    int waited;
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_rw = 1'b0; req_len = '0;

    vecs[0] = '{rw:1'b0, addr:7'h50, len:8'd2, wdata:'{8'hA5,8'h3C,8'h00,8'h00}, rxdata:'{8'h00,8'h00,8'h00,8'h00},
                nack_cmd:-1, addr_stall:0, wr_delay:0, n_cmd:5, exp_op:'{0,1,1,1,3,0,0,0},
                exp_tx:'{9'h1FF,9'h141,9'h14B,9'h079,9'h1FF,9'h000,9'h000,9'h000}, n_rd:0, n_wr:2, exp_nack:1'b0};
    vecs[1] = '{rw:1'b1, addr:7'h50, len:8'd3, wdata:'{8'h00,8'h00,8'h00,8'h00}, rxdata:'{8'h11,8'h22,8'h33,8'h00},
                nack_cmd:-1, addr_stall:0, wr_delay:0, n_cmd:6, exp_op:'{0,1,2,2,2,3,0,0},
                exp_tx:'{9'h1FF,9'h143,9'h1FE,9'h1FE,9'h1FF,9'h1FF,9'h000,9'h000}, n_rd:3, n_wr:0, exp_nack:1'b0};
    vecs[2] = '{rw:1'b0, addr:7'h20, len:8'd4, wdata:'{8'hDE,8'hAD,8'hBE,8'hEF}, rxdata:'{8'h00,8'h00,8'h00,8'h00},
                nack_cmd:1, addr_stall:0, wr_delay:0, n_cmd:3, exp_op:'{0,1,3,0,0,0,0,0},
                exp_tx:'{9'h1FF,9'h081,9'h1FF,9'h000,9'h000,9'h000,9'h000,9'h000}, n_rd:0, n_wr:0, exp_nack:1'b1};
    vecs[3] = '{rw:1'b0, addr:7'h68, len:8'd0, wdata:'{8'h77,8'h00,8'h00,8'h00}, rxdata:'{8'h00,8'h00,8'h00,8'h00},
                nack_cmd:-1, addr_stall:0, wr_delay:0, n_cmd:3, exp_op:'{0,1,3,0,0,0,0,0},
                exp_tx:'{9'h1FF,9'h1A1,9'h1FF,9'h000,9'h000,9'h000,9'h000,9'h000}, n_rd:0, n_wr:0, exp_nack:1'b0};
    vecs[4] = '{rw:1'b0, addr:7'h50, len:8'd1, wdata:'{8'h5A,8'h00,8'h00,8'h00}, rxdata:'{8'h00,8'h00,8'h00,8'h00},
                nack_cmd:-1, addr_stall:5, wr_delay:10, n_cmd:4, exp_op:'{0,1,1,3,0,0,0,0},
                exp_tx:'{9'h1FF,9'h141,9'h0B5,9'h1FF,9'h000,9'h000,9'h000,9'h000}, n_rd:0, n_wr:1, exp_nack:1'b0};
    vecs[5] = '{rw:1'b0, addr:7'h3A, len:8'd3, wdata:'{8'h01,8'h02,8'h03,8'h00}, rxdata:'{8'h00,8'h00,8'h00,8'h00},
                nack_cmd:3, addr_stall:0, wr_delay:0, n_cmd:5, exp_op:'{0,1,1,1,3,0,0,0},
                exp_tx:'{9'h1FF,9'h0E9,9'h003,9'h005,9'h1FF,9'h000,9'h000,9'h000}, n_rd:0, n_wr:2, exp_nack:1'b1};
    vecs[6] = '{rw:1'b1, addr:7'h7F, len:8'd1, wdata:'{8'h00,8'h00,8'h00,8'h00}, rxdata:'{8'hC3,8'h00,8'h00,8'h00},
                nack_cmd:-1, addr_stall:0, wr_delay:0, n_cmd:4, exp_op:'{0,1,2,3,0,0,0,0},
                exp_tx:'{9'h1FF,9'h1FF,9'h1FF,9'h1FF,9'h000,9'h000,9'h000,9'h000}, n_rd:1, n_wr:0, exp_nack:1'b0};
    vecs[7] = '{rw:1'b1, addr:7'h68, len:8'd0, wdata:'{8'h00,8'h00,8'h00,8'h00}, rxdata:'{8'h00,8'h00,8'h00,8'h00},
                nack_cmd:-1, addr_stall:0, wr_delay:0, n_cmd:3, exp_op:'{0,1,3,0,0,0,0,0},
                exp_tx:'{9'h1FF,9'h1A3,9'h1FF,9'h000,9'h000,9'h000,9'h000,9'h000}, n_rd:0, n_wr:0, exp_nack:1'b0};

    clear_env(vecs[0]);
    repeat (2) @(negedge clk);
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset outputs", {20'd0, cmd_valid, cmd_op, cmd_tx}, 32'd0);
    chk("reset pulses", {28'd0, wr_ready, rd_valid, done, nack_err}, 32'd0);
    chk("reset rd_data", {24'd0, rd_data}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset req_ready", {31'd0, req_ready}, 32'd1);

    for (int vi = 0; vi < 8; vi++) run_vec(vi);

    // Reset in the middle of a 3-byte read, right after the first byte arrives.
    clear_env(vecs[1]);
    issue_req(vecs[1], "mid_reset");
    waited = 0;
    while (rd_cnt == 0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (rd_cnt == 0) chk("mid_reset rd_timeout", 32'd0, 32'd1);
    reset_n = 1'b0; flush = 1'b1; tx_active = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_reset cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("mid_reset done", {30'd0, done, rd_valid}, 32'd0);
    repeat (2) @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_reset no_done", done_cnt, 32'd0);
    $display("txn mid_reset rd_before_reset=%0d done=%0d", rd_cnt, done_cnt);
    run_vec(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
